// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer with CDB capture and readyregs derivation.
// Define ROB_COMMIT_BYPASS_EN to let a CDB hit on the head entry retire at the same edge.
module reorder_buffer #(
   parameter int DEPTH = 16,
   parameter int NREGS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_valid,
   input  logic [3:0]       alloc_dest,
   input  logic             alloc_wen,
   output logic             alloc_ready,
   output logic [3:0]       alloc_robid,
   input  logic             cdbtransmit,
   input  logic [3:0]       cdbid,
   input  logic [7:0]       cdbval,
   output logic             commit_valid,
   output logic             commit_wen,
   output logic [3:0]       commit_reg,
   output logic [7:0]       commit_val,
   output logic [3:0]       commit_robid,
   output logic [NREGS-1:0] readyregs,
   output logic [4:0]       occupancy
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   logic [DEPTH-1:0] busy, done, wen;
   logic [3:0]       dest [DEPTH];
   logic [7:0]       val  [DEPTH];
   logic [AW-1:0]    head, tail, ci;
   logic [4:0]       count;
   logic             acc, hit, byp, cmt;

   assign ci          = cdbid[AW-1:0];
   assign alloc_ready = count != 5'(DEPTH);
   assign alloc_robid = 4'(tail);
   assign occupancy   = count;
   assign acc         = alloc_valid & alloc_ready;
   // The entry at tail is never busy when accepting, so a CDB aimed at it is dropped here.
   assign hit         = cdbtransmit & busy[ci] & ~done[ci];
`ifdef ROB_COMMIT_BYPASS_EN
   assign byp         = hit & (ci == head);
`else
   assign byp         = 1'b0;
`endif
   assign cmt         = (busy[head] & done[head]) | byp;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy         <= '0;
         done         <= '0;
         wen          <= '0;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         commit_valid <= 1'b0;
         commit_wen   <= 1'b0;
         commit_reg   <= '0;
         commit_val   <= '0;
         commit_robid <= '0;
      end else begin
         if (acc) begin
            busy[tail] <= 1'b1;
            done[tail] <= 1'b0;
            wen[tail]  <= alloc_wen;
            tail       <= tail + 1'b1;
         end
         if (hit & ~byp)
            done[ci] <= 1'b1;
         commit_valid <= cmt;
         if (cmt) begin
            busy[head]   <= 1'b0;
            done[head]   <= 1'b0;
            commit_wen   <= wen[head];
            commit_reg   <= dest[head];
            commit_val   <= done[head] ? val[head] : cdbval;
            commit_robid <= 4'(head);
            head         <= head + 1'b1;
         end
         count <= count + 5'(acc) - 5'(cmt);
      end
   end

   // Payload storage needs no reset; busy/done qualify every read.
   always_ff @(posedge clk) begin
      if (acc)
         dest[tail] <= alloc_dest;
      if (hit & ~byp)
         val[ci] <= cdbval;
   end

   always_comb begin
      readyregs = '1;
      for (int r = 0; r < NREGS; r++)
         for (int e = 0; e < DEPTH; e++)
            if (busy[e] & wen[e] & (dest[e] == 4'(r)))
               readyregs[r] = 1'b0;
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed plan plus random traffic against a queue-based ROB model.
module tb_reorder_buffer;
   logic        clk = 0, rst = 0;
   logic        alloc_valid = 0, alloc_wen = 0, cdbtransmit = 0;
   logic [3:0]  alloc_dest = 0, cdbid = 0;
   logic [7:0]  cdbval = 0;
   logic        alloc_ready, commit_valid, commit_wen;
   logic [3:0]  alloc_robid, commit_reg, commit_robid;
   logic [7:0]  commit_val;
   logic [15:0] readyregs;
   logic [4:0]  occupancy;

   reorder_buffer dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_wen(alloc_wen),
      .alloc_ready(alloc_ready), .alloc_robid(alloc_robid),
      .cdbtransmit(cdbtransmit), .cdbid(cdbid), .cdbval(cdbval),
      .commit_valid(commit_valid), .commit_wen(commit_wen), .commit_reg(commit_reg),
      .commit_val(commit_val), .commit_robid(commit_robid),
      .readyregs(readyregs), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] id;
      logic [3:0] dest;
      logic       wen;
      logic       done;
      logic [7:0] val;
   } ent_t;

   ent_t       q[$];
   logic [3:0] tl;
   logic       e_cv, e_wen;
   logic [3:0] e_reg, e_rid;
   logic [7:0] e_val;
   int         checks = 0, failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      tl = 0; e_cv = 0; e_wen = 0; e_reg = 0; e_rid = 0; e_val = 0;
   endtask

   function automatic logic [15:0] exp_ready();
      logic [15:0] r = '1;
      foreach (q[i]) if (q[i].wen) r[q[i].dest] = 1'b0;
      return r;
   endfunction

   task automatic compare();
      check("alloc_ready", alloc_ready, q.size() != 16);
      check("alloc_robid", alloc_robid, tl);
      check("occupancy", occupancy, q.size());
      check("readyregs", readyregs, exp_ready());
      check("commit_valid", commit_valid, e_cv);
      check("commit_wen", commit_wen, e_wen);
      check("commit_reg", commit_reg, e_reg);
      check("commit_val", commit_val, e_val);
      check("commit_robid", commit_robid, e_rid);
   endtask

   // Applies one clock edge to the model using the inputs currently driven.
   task automatic model_edge();
      bit   c = 0, byp = 0;
      int   n = q.size();
      ent_t h;
      if (n > 0) begin
         if (q[0].done) c = 1;
`ifdef ROB_COMMIT_BYPASS_EN
         else if (cdbtransmit && cdbid == q[0].id) begin c = 1; byp = 1; end
`endif
      end
      if (cdbtransmit)
         foreach (q[i])
            if (q[i].id == cdbid && !q[i].done && !(byp && i == 0)) begin
               q[i].done = 1;
               q[i].val  = cdbval;
            end
      e_cv = c;
      if (c) begin
         h = q.pop_front();
         e_wen = h.wen; e_reg = h.dest; e_rid = h.id;
         e_val = byp ? cdbval : h.val;
      end
      if (alloc_valid && n != 16) begin
         q.push_back('{tl, alloc_dest, alloc_wen, 1'b0, 8'h00});
         tl++;
      end
   endtask

   task automatic step(input logic av, input logic [3:0] ad, input logic aw,
                       input logic ct, input logic [3:0] cid, input logic [7:0] cv);
      compare();
      alloc_valid = av; alloc_dest = ad; alloc_wen = aw;
      cdbtransmit = ct; cdbid = cid; cdbval = cv;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 0;
      alloc_valid = 0; cdbtransmit = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1;
   endtask

   initial begin
      model_reset();
      do_reset();
      check("rst_ready", alloc_ready, 1);
      check("rst_rdyregs", readyregs, 16'hFFFF);
      check("rst_occ", occupancy, 0);

      // single writer round trip
      step(1, 3, 1, 0, 0, 0);
      check("t1_rdy0", readyregs[3], 0);
      step(0, 0, 0, 1, 0, 8'h5A);
`ifndef ROB_COMMIT_BYPASS_EN
      check("t1_wait", commit_valid, 0);
      idle(1);
`endif
      check("t1_cv", commit_valid, 1);
      check("t1_reg", commit_reg, 3);
      check("t1_val", commit_val, 8'h5A);
      check("t1_rid", commit_robid, 0);
      check("t1_rdy1", readyregs[3], 1);
      idle(1);

      // out-of-order completion, in-order retirement
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 4'(i + 1), 1, 0, 0, 0);
      for (int i = 2; i >= 0; i--) step(0, 0, 0, 1, 4'(i), 8'(8'h10 + i));
      idle(4);
      check("t2_last_rid", commit_robid, 2);
      check("t2_last_val", commit_val, 8'h12);

      // fill, full stall, wrap
      do_reset();
      for (int i = 0; i < 16; i++) step(1, 4'(i), 1, 0, 0, 0);
      check("t3_full", alloc_ready, 0);
      check("t3_occ", occupancy, 16);
      step(1, 4'hF, 1, 1, 0, 8'h77);
      step(1, 4'hE, 1, 0, 0, 0);
      idle(1);
      check("t3_ready", alloc_ready, 1);
      check("t3_wrap_id", alloc_robid, 0);
      step(1, 4'h9, 0, 0, 0, 0);
      check("t3_occ2", occupancy, 16);

      // two writers to one register
      do_reset();
      step(1, 5, 1, 0, 0, 0);
      step(1, 5, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 8'h01);
      idle(2);
      check("t4_still_busy", readyregs[5], 0);
      step(0, 0, 0, 1, 1, 8'h02);
      idle(2);
      check("t4_free", readyregs[5], 1);

      // stray and duplicate broadcasts
      do_reset();
      step(1, 7, 1, 0, 0, 0);
      step(1, 8, 1, 0, 0, 0);
      step(0, 0, 0, 1, 9, 8'hEE);
      step(0, 0, 0, 1, 1, 8'h11);
      step(0, 0, 0, 1, 1, 8'h22);
      step(0, 0, 0, 1, 0, 8'h33);
      idle(3);
      check("t5_val", commit_val, 8'h11);
      check("t5_rid", commit_robid, 1);

      // asynchronous reset with a commit pending
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 4'(i + 2), 1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 8'h44);
      #2 rst = 0;
      #1;
      model_reset();
      check("t6_cv", commit_valid, 0);
      check("t6_rdy", readyregs, 16'hFFFF);
      check("t6_occ", occupancy, 0);
      check("t6_robid", alloc_robid, 0);
      @(negedge clk);
      rst = 1;
      idle(2);

      // random traffic; the busy phase lets the buffer fill
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic [3:0] id;
         int         pa = (i % 200 < 80) ? 90 : 50;
         id = (q.size() > 0 && $urandom_range(3) != 0) ? q[$urandom_range(q.size() - 1)].id
                                                       : 4'($urandom_range(15));
         step($urandom_range(99) < pa, 4'($urandom_range(15)), 1'($urandom_range(1)),
              $urandom_range(99) < (100 - pa), id, 8'($urandom_range(255)));
      end
      idle(20);
      compare();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
